// File: rtl/led_value_formatter.sv
// 32-bit value to eight 7-segment digit patterns, with a sequential double-dabble
// engine for decimal, direct hex mapping, leading-zero blanking and overflow dashes.
module led_value_formatter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] value_i,
  input  logic        hex_i,
  input  logic        blank_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        ovf_o,
  output logic [55:0] digits_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] ENCODE  = 2'd2;

  localparam logic [31:0] DEC_MAX = 32'd99_999_999;

  logic [1:0]  state;
  logic [31:0] value_reg;
  logic [31:0] bcd;
  logic [4:0]  cnt;
  logic        hex_mode;
  logic        blank_mode;
  logic        ovf_flag;

  logic [31:0] bcd_adj;
  logic [63:0] shifted;
  logic [31:0] nibbles;
  logic [55:0] next_digits;
  logic        leading;
  logic [3:0]  nib;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  // One double-dabble step: correct every nibble >= 5, then shift value into bcd.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 8; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    shifted = {bcd_adj, value_reg} << 1;
  end

  // Blanking walks from the MSB digit down and stops at the first non-zero nibble;
  // the least-significant digit always shows.
  always_comb begin
    nibbles     = hex_mode ? value_reg : bcd;
    next_digits = '0;
    leading     = blank_mode;
    nib         = '0;
    for (int i = 7; i >= 0; i--) begin
      nib = nibbles[i*4 +: 4];
      if (ovf_flag) begin
        next_digits[i*7 +: 7] = 7'h40;
      end else if (leading && nib == 4'h0 && i != 0) begin
        next_digits[i*7 +: 7] = 7'h00;
      end else begin
        next_digits[i*7 +: 7] = seg7(nib);
        leading = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      value_reg  <= '0;
      bcd        <= '0;
      cnt        <= '0;
      hex_mode   <= 1'b0;
      blank_mode <= 1'b0;
      ovf_flag   <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      ovf_o      <= 1'b0;
      digits_o   <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (load_i) begin
            value_reg  <= value_i;
            hex_mode   <= hex_i;
            blank_mode <= blank_i;
            busy_o     <= 1'b1;
            bcd        <= '0;
            cnt        <= '0;
            if (hex_i) begin
              ovf_flag <= 1'b0;
              state    <= ENCODE;
            end else if (value_i > DEC_MAX) begin
              ovf_flag <= 1'b1;
              state    <= ENCODE;
            end else begin
              ovf_flag <= 1'b0;
              state    <= CONVERT;
            end
          end
        end
        CONVERT: begin
          {bcd, value_reg} <= shifted;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31)
            state <= ENCODE;
        end
        ENCODE: begin
          digits_o <= next_digits;
          ovf_o    <= ovf_flag;
          done_o   <= 1'b1;
          busy_o   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
